// File: rtl/jelly_video_format_regularizer_sequencer_if.sv
// Wishbone bus between the regularizer sequencer (master) and the regularizer register slave.

interface jelly_video_format_regularizer_sequencer_if #(
  parameter int WB_ADR_WIDTH = 8,
  parameter int WB_DAT_WIDTH = 32,
  parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
) ();

  logic [WB_ADR_WIDTH-1:0] m_wb_adr_o;
  logic [WB_DAT_WIDTH-1:0] m_wb_dat_o;
  logic [WB_DAT_WIDTH-1:0] m_wb_dat_i;
  logic                    m_wb_we_o;
  logic [WB_SEL_WIDTH-1:0] m_wb_sel_o;
  logic                    m_wb_stb_o;
  logic                    m_wb_ack_i;

  modport master (
    output m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
    input  m_wb_dat_i, m_wb_ack_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_dat_o, m_wb_we_o, m_wb_sel_o, m_wb_stb_o,
    output m_wb_dat_i, m_wb_ack_i
  );

endinterface

// File: rtl/jelly_video_format_regularizer_sequencer.sv
// Programs a video format regularizer over Wishbone, then confirms the format by counting output frame
// starts. Define VIDEO_REG_SEQ_READBACK_EN to read back and verify every register after it is written.

module jelly_video_format_regularizer_sequencer #(
  parameter int                      WB_ADR_WIDTH   = 8,
  parameter int                      WB_DAT_WIDTH   = 32,
  parameter int                      WB_SEL_WIDTH   = WB_DAT_WIDTH / 8,
  parameter int                      X_WIDTH        = 12,
  parameter int                      Y_WIDTH        = 12,
  parameter int                      TDATA_WIDTH    = 24,
  parameter int                      TIMER_WIDTH    = 32,
  parameter logic [1:0]              CTL_VALUE      = 2'b11,
  parameter logic [WB_ADR_WIDTH-1:0] ADR_CTL        = WB_ADR_WIDTH'(8'h04),
  parameter logic [WB_ADR_WIDTH-1:0] ADR_WIDTH      = WB_ADR_WIDTH'(8'h08),
  parameter logic [WB_ADR_WIDTH-1:0] ADR_HEIGHT     = WB_ADR_WIDTH'(8'h09),
  parameter logic [WB_ADR_WIDTH-1:0] ADR_FILL       = WB_ADR_WIDTH'(8'h0a),
  parameter logic [WB_ADR_WIDTH-1:0] ADR_TIMEOUT    = WB_ADR_WIDTH'(8'h0b),
  parameter int                      CONFIRM_FRAMES = 2,
  parameter int                      WDOG_WIDTH     = 24
) (
  input  logic                   aresetn,
  input  logic                   aclk,

  input  logic                   start,
  input  logic [X_WIDTH-1:0]     param_width,
  input  logic [Y_WIDTH-1:0]     param_height,
  input  logic [TDATA_WIDTH-1:0] param_fill,
  input  logic [TIMER_WIDTH-1:0] param_timeout,
  input  logic [WDOG_WIDTH-1:0]  wdog_limit,

  output logic                   busy,
  output logic                   done,
  output logic                   error,

  jelly_video_format_regularizer_sequencer_if.master m_wb,

  input  logic                   mon_tuser,
  input  logic                   mon_tvalid,
  input  logic                   mon_tready
);

  localparam int FRAME_CNT_W = $clog2(CONFIRM_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WIDTH,
    ST_WR_HEIGHT,
    ST_WR_FILL,
    ST_WR_TIMEOUT,
    ST_WR_CTL,
    ST_WAIT_FRAME
  } state_t;

  // Sub-steps of one register access: address setup, write strobe, then optional readback.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_WRITE,
    PH_RD_SETUP,
    PH_READ
  } phase_t;

  state_t                   state;
  state_t                   reg_next;
  phase_t                   phase;
  logic [WB_ADR_WIDTH-1:0]  reg_adr;
  logic [WB_DAT_WIDTH-1:0]  reg_dat;
`ifdef VIDEO_REG_SEQ_READBACK_EN
  logic [WB_DAT_WIDTH-1:0]  reg_mask;
`endif

  logic [X_WIDTH-1:0]       lat_width;
  logic [Y_WIDTH-1:0]       lat_height;
  logic [TDATA_WIDTH-1:0]   lat_fill;
  logic [TIMER_WIDTH-1:0]   lat_timeout;
  logic [WDOG_WIDTH-1:0]    lat_wdog;

  logic [WDOG_WIDTH-1:0]    wdog_cnt;
  logic [FRAME_CNT_W-1:0]   frame_cnt;
  logic                     frame_start;

  assign frame_start = mon_tuser & mon_tvalid & mon_tready;

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    reg_adr  = '0;
    reg_dat  = '0;
    reg_next = ST_WAIT_FRAME;
`ifdef VIDEO_REG_SEQ_READBACK_EN
    reg_mask = '0;
`endif
    case (state)
      ST_WR_WIDTH: begin
        reg_adr  = ADR_WIDTH;
        reg_dat  = WB_DAT_WIDTH'(lat_width);
        reg_next = ST_WR_HEIGHT;
`ifdef VIDEO_REG_SEQ_READBACK_EN
        reg_mask = WB_DAT_WIDTH'({X_WIDTH{1'b1}});
`endif
      end
      ST_WR_HEIGHT: begin
        reg_adr  = ADR_HEIGHT;
        reg_dat  = WB_DAT_WIDTH'(lat_height);
        reg_next = ST_WR_FILL;
`ifdef VIDEO_REG_SEQ_READBACK_EN
        reg_mask = WB_DAT_WIDTH'({Y_WIDTH{1'b1}});
`endif
      end
      ST_WR_FILL: begin
        reg_adr  = ADR_FILL;
        reg_dat  = WB_DAT_WIDTH'(lat_fill);
        reg_next = ST_WR_TIMEOUT;
`ifdef VIDEO_REG_SEQ_READBACK_EN
        reg_mask = WB_DAT_WIDTH'({TDATA_WIDTH{1'b1}});
`endif
      end
      ST_WR_TIMEOUT: begin
        reg_adr  = ADR_TIMEOUT;
        reg_dat  = WB_DAT_WIDTH'(lat_timeout);
        reg_next = ST_WR_CTL;
`ifdef VIDEO_REG_SEQ_READBACK_EN
        reg_mask = WB_DAT_WIDTH'({TIMER_WIDTH{1'b1}});
`endif
      end
      ST_WR_CTL: begin
        reg_adr  = ADR_CTL;
        reg_dat  = WB_DAT_WIDTH'(CTL_VALUE);
        reg_next = ST_WAIT_FRAME;
`ifdef VIDEO_REG_SEQ_READBACK_EN
        reg_mask = WB_DAT_WIDTH'(2'b11);
`endif
      end
      default: ;
    endcase
  end

  // NOTE: the parameter latch carries no reset; it is only read after an accepted start has loaded it.
  always_ff @(posedge aclk) begin
    if (aresetn && state == ST_IDLE && start) begin
      lat_width   <= param_width;
      lat_height  <= param_height;
      lat_fill    <= param_fill;
      lat_timeout <= param_timeout;
      lat_wdog    <= wdog_limit;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state           <= ST_IDLE;
      phase           <= PH_SETUP;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      wdog_cnt        <= '0;
      frame_cnt       <= '0;
      m_wb.m_wb_adr_o <= '0;
      m_wb.m_wb_dat_o <= '0;
      m_wb.m_wb_we_o  <= 1'b0;
      m_wb.m_wb_sel_o <= '0;
      m_wb.m_wb_stb_o <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            error <= 1'b0;
            busy  <= 1'b1;
            phase <= PH_SETUP;
            state <= ST_WR_WIDTH;
          end
        end

        ST_WR_WIDTH, ST_WR_HEIGHT, ST_WR_FILL, ST_WR_TIMEOUT, ST_WR_CTL: begin
          wdog_cnt  <= '0;
          frame_cnt <= '0;
          case (phase)
            PH_SETUP: begin
              m_wb.m_wb_adr_o <= reg_adr;
              m_wb.m_wb_dat_o <= reg_dat;
              m_wb.m_wb_we_o  <= 1'b1;
              m_wb.m_wb_sel_o <= '1;
              m_wb.m_wb_stb_o <= 1'b1;
              phase           <= PH_WRITE;
            end
            PH_WRITE: begin
              if (m_wb.m_wb_ack_i) begin
                m_wb.m_wb_stb_o <= 1'b0;
`ifdef VIDEO_REG_SEQ_READBACK_EN
                phase           <= PH_RD_SETUP;
`else
                phase           <= PH_SETUP;
                state           <= reg_next;
`endif
              end
            end
`ifdef VIDEO_REG_SEQ_READBACK_EN
            PH_RD_SETUP: begin
              m_wb.m_wb_we_o  <= 1'b0;
              m_wb.m_wb_stb_o <= 1'b1;
              phase           <= PH_READ;
            end
            PH_READ: begin
              if (m_wb.m_wb_ack_i) begin
                m_wb.m_wb_stb_o <= 1'b0;
                phase           <= PH_SETUP;
                if ((m_wb.m_wb_dat_i & reg_mask) != m_wb.m_wb_dat_o) begin
                  error <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                end else begin
                  state <= reg_next;
                end
              end
            end
`endif
            default: phase <= PH_SETUP;
          endcase
        end

        ST_WAIT_FRAME: begin
          // A frame start outranks a watchdog expiry on the same cycle.
          if (frame_start) begin
            wdog_cnt <= '0;
            if (frame_cnt == FRAME_CNT_W'(CONFIRM_FRAMES - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end else if (lat_wdog != '0 && wdog_cnt == lat_wdog - WDOG_WIDTH'(1)) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (wdog_cnt != '1) begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
